// File: rtl/srl_fifo_mc.sv
// srl_fifo_mc: NCH independent shift-register FIFOs with first-word fall-through.
// Ports (channel c occupies slice c of every vector):
//   ap_clk, ap_rst_n            clock, async active-low reset
//   if_write, if_din            write request / data (DATA_WIDTH per channel)
//   if_full_n, if_almost_full_n registered not-full / below almost-full threshold
//   if_read, if_dout            read request / head word (combinational)
//   if_empty_n                  registered not-empty
//   flush                       per-channel synchronous clear
//   count                       per-channel occupancy (CW bits each)
//   err_ovf, err_udf            sticky overflow / underflow flags
module srl_fifo_mc #(
  parameter  int DATA_WIDTH = 1,
  parameter  int DEPTH      = 2,
  parameter  int NCH        = 4,
  parameter  int AF_MARGIN  = 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [NCH-1:0]        if_write,
  input  logic [NCH*DATA_WIDTH-1:0] if_din,
  output logic [NCH-1:0]        if_full_n,
  output logic [NCH-1:0]        if_almost_full_n,
  input  logic [NCH-1:0]        if_read,
  output logic [NCH*DATA_WIDTH-1:0] if_dout,
  output logic [NCH-1:0]        if_empty_n,
  input  logic [NCH-1:0]        flush,
  output logic [NCH*CW-1:0]     count,
  output logic [NCH-1:0]        err_ovf,
  output logic [NCH-1:0]        err_udf
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_dout;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_full_n, r_afull_n, r_empty_n, r_ovf, r_udf;
    logic                  w_wr, w_rd;
    // Flush discards any same-cycle write or read.
    assign w_wr = if_write[c] & r_full_n & ~flush[c];
    assign w_rd = if_read[c] & r_empty_n & ~flush[c];
    always_comb w_cnt_nxt = flush[c] ? '0 : r_cnt + CW'(w_wr) - CW'(w_rd);
    // Head word is the oldest entry, at index count-1.
    always_comb begin
      w_dout = '0;
      for (int i = 0; i < DEPTH; i++)
        if (r_cnt == CW'(i + 1)) w_dout = r_mem[i];
    end
    always_ff @(posedge ap_clk) begin
      if (w_wr) begin
        r_mem[0] <= if_din[c*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        r_cnt     <= '0;
        r_full_n  <= 1'b1;
        r_afull_n <= 1'b1;
        r_empty_n <= 1'b0;
        r_ovf     <= 1'b0;
        r_udf     <= 1'b0;
      end else begin
        r_cnt     <= w_cnt_nxt;
        r_full_n  <= w_cnt_nxt != CW'(DEPTH);
        r_afull_n <= w_cnt_nxt < CW'(DEPTH - AF_MARGIN);
        r_empty_n <= w_cnt_nxt != '0;
        r_ovf     <= ~flush[c] & (r_ovf | (if_write[c] & ~r_full_n));
        r_udf     <= ~flush[c] & (r_udf | (if_read[c] & ~r_empty_n));
      end
    end
    assign if_dout[c*DATA_WIDTH +: DATA_WIDTH] = w_dout;
    assign count[c*CW +: CW] = r_cnt;
    assign if_full_n[c]        = r_full_n;
    assign if_almost_full_n[c] = r_afull_n;
    assign if_empty_n[c]       = r_empty_n;
    assign err_ovf[c]          = r_ovf;
    assign err_udf[c]          = r_udf;
  end
endmodule

// File: tb/tb_srl_fifo_mc.sv
// tb_srl_fifo_mc: directed self-checking bench for srl_fifo_mc (DEPTH=4, DATA_WIDTH=8, NCH=4, AF_MARGIN=1).
module tb_srl_fifo_mc;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [3:0]  if_write, if_read, flush;
  logic [31:0] if_din;
  logic [3:0]  if_full_n, if_almost_full_n, if_empty_n, err_ovf, err_udf;
  logic [31:0] if_dout;
  logic [11:0] count;
  int passed = 0;
  int total  = 0;
  srl_fifo_mc #(.DATA_WIDTH(8), .DEPTH(4), .NCH(4), .AF_MARGIN(1)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_almost_full_n(if_almost_full_n), .if_read(if_read), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .flush(flush), .count(count),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'h0);
    chk({tag, "_empty_n"}, 32'(if_empty_n), 32'h0);
    chk({tag, "_full_n"}, 32'(if_full_n), 32'hF);
    chk({tag, "_afull_n"}, 32'(if_almost_full_n), 32'hF);
    chk({tag, "_ovf"}, 32'(err_ovf), 32'h0);
    chk({tag, "_udf"}, 32'(err_udf), 32'h0);
  endtask
  initial begin
    logic [7:0] seq0 [4];
    seq0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    ap_rst_n = 1'b1;
    if_write = '0; if_read = '0; flush = '0; if_din = '0;
    #2 ap_rst_n = 1'b0;
    #1 chk_reset_state("rst_async");
    // write attempt on an edge while still in reset must be ignored
    if_write = 4'b0001; if_din[7:0] = 8'hEE;
    tick();
    chk("rst_edge_count0", 32'(count[2:0]), 32'h0);
    chk("rst_edge_empty", 32'(if_empty_n), 32'h0);
    if_write = '0;
    ap_rst_n = 1'b1;
    tick();
    // ch0 fill and drain
    if_write = 4'b0001;
    if_din[7:0] = 8'h11; tick();
    chk("ch0_fwft_dout", 32'(if_dout[7:0]), 32'h11);
    chk("ch0_fwft_empty_n", 32'(if_empty_n[0]), 32'h1);
    if_din[7:0] = 8'h22; tick();
    chk("ch0_afull_n_w2", 32'(if_almost_full_n[0]), 32'h1);
    if_din[7:0] = 8'h33; tick();
    chk("ch0_afull_n_w3", 32'(if_almost_full_n[0]), 32'h0);
    chk("ch0_full_n_w3", 32'(if_full_n[0]), 32'h1);
    if_din[7:0] = 8'h44; tick();
    chk("ch0_full_n_w4", 32'(if_full_n[0]), 32'h0);
    chk("ch0_count_w4", 32'(count[2:0]), 32'h4);
    if_write = '0; if_read = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      chk("ch0_read_head", 32'(if_dout[7:0]), 32'(seq0[i]));
      tick();
    end
    if_read = '0;
    chk("ch0_empty_after", 32'(if_empty_n[0]), 32'h0);
    chk("ch0_count_after", 32'(count[2:0]), 32'h0);
    // ch1: full, write+read together drops the write
    if_write = 4'b0010;
    for (int i = 1; i <= 4; i++) begin
      if_din[15:8] = 8'(8'hA0 + i);
      tick();
    end
    chk("ch1_full", 32'(if_full_n[1]), 32'h0);
    if_din[15:8] = 8'h55; if_read = 4'b0010;
    chk("ch1_head_A1", 32'(if_dout[15:8]), 32'hA1);
    tick();
    if_write = '0;
    chk("ch1_count3", 32'(count[5:3]), 32'h3);
    chk("ch1_ovf", 32'(err_ovf[1]), 32'h1);
    chk("ch1_head_A2", 32'(if_dout[15:8]), 32'hA2);
    tick();
    chk("ch1_head_A3", 32'(if_dout[15:8]), 32'hA3);
    tick();
    chk("ch1_head_A4", 32'(if_dout[15:8]), 32'hA4);
    tick();
    if_read = '0;
    chk("ch1_drained", 32'(count[5:3]), 32'h0);
    chk("ch1_ovf_sticky", 32'(err_ovf[1]), 32'h1);
    // ch2: empty, write+read together drops the read
    if_write = 4'b0100; if_read = 4'b0100; if_din[23:16] = 8'hA5;
    tick();
    chk("ch2_count1", 32'(count[8:6]), 32'h1);
    chk("ch2_dout", 32'(if_dout[23:16]), 32'hA5);
    chk("ch2_udf", 32'(err_udf[2]), 32'h1);
    // flush wins over simultaneous write/read and reports no errors
    flush = 4'b0100;
    tick();
    flush = '0; if_write = '0; if_read = '0;
    chk("ch2_flush_count", 32'(count[8:6]), 32'h0);
    chk("ch2_flush_udf", 32'(err_udf[2]), 32'h0);
    chk("ch2_flush_empty_n", 32'(if_empty_n[2]), 32'h0);
    chk("ch2_flush_full_n", 32'(if_full_n[2]), 32'h1);
    tick();
    chk("ch2_flush_hold", 32'(count[8:6]), 32'h0);
    // ch3: steady-state streaming at depth 2
    if_write = 4'b1000;
    if_din[31:24] = 8'h01; tick();
    if_din[31:24] = 8'h02; tick();
    chk("ch3_count2", 32'(count[11:9]), 32'h2);
    if_read = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      if_din[31:24] = 8'(8'h10 + i);
      chk("ch3_stream_head", 32'(if_dout[31:24]), (i == 0) ? 32'h01 : (i == 1) ? 32'h02 : 32'(8'h10 + i - 2));
      tick();
      chk("ch3_stream_count", 32'(count[11:9]), 32'h2);
    end
    if_write = '0; if_read = '0;
    chk("ch3_others_count", 32'(count[8:0]), 32'h0);
    chk("ch3_others_ovf", 32'(err_ovf), 32'h2);
    chk("ch3_others_udf", 32'(err_udf), 32'h0);
    chk("ch3_others_empty", 32'(if_empty_n), 32'h8);
    // async reset mid-stream
    if_write = 4'b0001; if_din[7:0] = 8'h99; tick();
    if_din[7:0] = 8'h98; tick();
    if_write = '0;
    chk("pre_rst_count0", 32'(count[2:0]), 32'h2);
    #1 ap_rst_n = 1'b0;
    #1 chk_reset_state("rst_mid");
    #1 ap_rst_n = 1'b1;
    tick();
    if_write = 4'b0001; if_din[7:0] = 8'h77;
    tick();
    if_write = '0;
    chk("post_rst_head", 32'(if_dout[7:0]), 32'h77);
    chk("post_rst_count", 32'(count[2:0]), 32'h1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
